mole_draw_sequencer: RTL and testbench

MOLE_DRAW_SEQUENCER -- requirements
Module: mole_draw_sequencer

---
 rtl/mole_draw_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mole_draw_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mole_draw_sequencer.sv
// Walks the 3x3 mole grid and issues one box-draw command per hole whose
// state changed. Define MOLE_FULL_REDRAW_EN to redraw all 9 holes on every update.
module mole_draw_sequencer #(
  parameter int unsigned X0          = 40,
  parameter int unsigned Y0          = 30,
  parameter int unsigned X_PITCH     = 80,
  parameter int unsigned Y_PITCH     = 60,
  parameter logic [2:0]  MOLE_COLOUR = 3'b100,
  parameter logic [2:0]  HOLE_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iUpdate,
  input  logic [8:0] iMoleMask,
  input  logic       iDrawDone,
  output logic       oPlotBox,
  output logic [8:0] oStart_X,
  output logic [7:0] oStart_Y,
  output logic [2:0] oColour,
  output logic       oBusy,
  output logic       oFrameDone
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SCAN   = 3'd1;
  localparam logic [2:0] S_ISSUE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0] state_q, state_d;
  logic [8:0] target_q, target_d;
  logic [8:0] shown_q, shown_d;
  logic       shown_valid_q, shown_valid_d;
  logic [3:0] idx_q, idx_d;
  logic [8:0] pend_mask_q, pend_mask_d;
  logic       pend_q, pend_d;
  logic [8:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [2:0] col_q, col_d;

  logic [1:0]  hole_col, hole_row;
  logic [31:0] hole_x, hole_y;
  logic        need_draw;

  always_comb begin
    hole_col = 2'd0;
    hole_row = 2'd0;
    case (idx_q)
      4'd0: begin hole_col = 2'd0; hole_row = 2'd0; end
      4'd1: begin hole_col = 2'd1; hole_row = 2'd0; end
      4'd2: begin hole_col = 2'd2; hole_row = 2'd0; end
      4'd3: begin hole_col = 2'd0; hole_row = 2'd1; end
      4'd4: begin hole_col = 2'd1; hole_row = 2'd1; end
      4'd5: begin hole_col = 2'd2; hole_row = 2'd1; end
      4'd6: begin hole_col = 2'd0; hole_row = 2'd2; end
      4'd7: begin hole_col = 2'd1; hole_row = 2'd2; end
      4'd8: begin hole_col = 2'd2; hole_row = 2'd2; end
      default: begin hole_col = 2'd0; hole_row = 2'd0; end
    endcase
    hole_x = X0 + 32'(hole_col) * X_PITCH;
    hole_y = Y0 + 32'(hole_row) * Y_PITCH;
  end

`ifdef MOLE_FULL_REDRAW_EN
  assign need_draw = 1'b1;
`else
  assign need_draw = !shown_valid_q || (target_q[idx_q] != shown_q[idx_q]);
`endif

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    shown_d       = shown_q;
    shown_valid_d = shown_valid_q;
    idx_d         = idx_q;
    pend_mask_d   = pend_mask_q;
    pend_d        = pend_q;
    x_d           = x_q;
    y_d           = y_q;
    col_d         = col_q;

    // Mid-sequence updates park in the one-deep pending slot; FINISH consumes them directly.
    if (iUpdate && state_q != S_IDLE && state_q != S_FINISH) begin
      pend_mask_d = iMoleMask;
      pend_d      = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (iUpdate) begin
          target_d = iMoleMask;
          idx_d    = 4'd0;
          state_d  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (need_draw) begin
          x_d     = hole_x[8:0];
          y_d     = hole_y[7:0];
          col_d   = target_q[idx_q] ? MOLE_COLOUR : HOLE_COLOUR;
          state_d = S_ISSUE;
        end else if (idx_q == 4'd8) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (iDrawDone) begin
          shown_d[idx_q] = target_q[idx_q];
          if (idx_q == 4'd8) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SCAN;
          end
        end
      end
      S_FINISH: begin
        shown_valid_d = 1'b1;
        if (iUpdate) begin
          target_d = iMoleMask;
          pend_d   = 1'b0;
          idx_d    = 4'd0;
          state_d  = S_SCAN;
        end else if (pend_q) begin
          target_d = pend_mask_q;
          pend_d   = 1'b0;
          idx_d    = 4'd0;
          state_d  = S_SCAN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      shown_q       <= '0;
      shown_valid_q <= 1'b0;
      idx_q         <= '0;
      pend_mask_q   <= '0;
      pend_q        <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      col_q         <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      shown_q       <= shown_d;
      shown_valid_q <= shown_valid_d;
      idx_q         <= idx_d;
      pend_mask_q   <= pend_mask_d;
      pend_q        <= pend_d;
      x_q           <= x_d;
      y_q           <= y_d;
      col_q         <= col_d;
    end
  end

  assign oPlotBox   = (state_q == S_ISSUE);
  assign oFrameDone = (state_q == S_FINISH);
  assign oBusy      = (state_q != S_IDLE);
  assign oStart_X   = x_q;
  assign oStart_Y   = y_q;
  assign oColour    = col_q;

endmodule

// File: tb/tb_mole_draw_sequencer.sv
// Scoreboard bench for mole_draw_sequencer: expected draw commands and frame-done
// pulses are queued when an update is issued and popped by an independent monitor.
module tb_mole_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       iUpdate;
  logic [8:0] iMoleMask;
  logic       iDrawDone;
  logic       oPlotBox;
  logic [8:0] oStart_X;
  logic [7:0] oStart_Y;
  logic [2:0] oColour;
  logic       oBusy;
  logic       oFrameDone;

  mole_draw_sequencer #(
    .X0(40), .Y0(30), .X_PITCH(80), .Y_PITCH(60),
    .MOLE_COLOUR(3'b100), .HOLE_COLOUR(3'b010)
  ) dut (
    .clk(clk), .reset(reset), .iUpdate(iUpdate), .iMoleMask(iMoleMask),
    .iDrawDone(iDrawDone), .oPlotBox(oPlotBox), .oStart_X(oStart_X),
    .oStart_Y(oStart_Y), .oColour(oColour), .oBusy(oBusy), .oFrameDone(oFrameDone)
  );

  always #5 clk = ~clk;

`ifdef MOLE_FULL_REDRAW_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  typedef struct {
    bit         frame;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    bit         lat;
  } ev_t;

  ev_t  exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   upd_cyc = 0;
  int   drawer_dly = 3;
  bit   outstanding = 0;
  logic [8:0] m_shown = '0;
  bit         m_valid = 0;
  logic [19:0] held;
  event plot_ev;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: a frame draws each hole that differs from what is on screen.
  task automatic expect_frame(input logic [8:0] mask, input bit lat);
    ev_t e;
    for (int n = 0; n < 9; n++) begin
      if (!m_valid || FULL || mask[n] != m_shown[n]) begin
        e.frame = 0;
        e.x = 9'(40 + (n % 3) * 80);
        e.y = 8'(30 + (n / 3) * 60);
        e.c = mask[n] ? 3'b100 : 3'b010;
        e.lat = 0;
        exp_q.push_back(e);
      end
    end
    m_shown = mask;
    m_valid = 1;
    e.frame = 1; e.x = '0; e.y = '0; e.c = '0; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic pulse(input logic [8:0] mask);
    iMoleMask = mask;
    iUpdate = 1'b1;
    @(negedge clk);
    iUpdate = 1'b0;
  endtask

  task automatic do_update(input logic [8:0] mask, input bit lat);
    upd_cyc = cyc;
    expect_frame(mask, lat);
    pulse(mask);
  endtask

  task automatic wait_idle(input int max);
    int t = 0;
    while ((oBusy || exp_q.size() != 0) && t < max) begin
      @(negedge clk);
      t++;
    end
    chk(t < max, "idle_timeout", t, max);
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t e;
    if (!reset) begin
      if (oPlotBox) begin
        chk(!outstanding, "double_plot", 32'(outstanding), 0);
        if (exp_q.size() == 0 || exp_q[0].frame) begin
          chk(0, "unexpected_plot", {12'd0, oStart_X, oStart_Y, oColour}, 0);
        end else begin
          e = exp_q.pop_front();
          chk({oStart_X, oStart_Y, oColour} == {e.x, e.y, e.c}, "plot_xyc",
              {12'd0, oStart_X, oStart_Y, oColour}, {12'd0, e.x, e.y, e.c});
        end
        held = {oStart_X, oStart_Y, oColour};
        outstanding = 1;
        -> plot_ev;
      end else if (outstanding) begin
        chk({oStart_X, oStart_Y, oColour} == held, "hold_stable",
            {12'd0, oStart_X, oStart_Y, oColour}, {12'd0, held});
      end
      if (oFrameDone) begin
        if (exp_q.size() == 0 || !exp_q[0].frame) begin
          chk(0, "unexpected_frame_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk(1, "frame_done", 1, 1);
          if (e.lat) chk(cyc - upd_cyc == 10, "frame_latency", cyc - upd_cyc, 10);
        end
      end
    end
  end

  // Box drawer model
  initial begin
    forever begin
      @(plot_ev);
      repeat (drawer_dly) @(negedge clk);
      iDrawDone = 1'b1;
      outstanding = 0;
      @(negedge clk);
      iDrawDone = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] m;
    int t;
    reset = 1'b1; iUpdate = 1'b0; iMoleMask = '0; iDrawDone = 1'b0;
    repeat (3) @(negedge clk);
    chk(!oBusy && !oPlotBox && !oFrameDone, "reset_ctrl", {oBusy, oPlotBox, oFrameDone}, 0);
    chk({oStart_X, oStart_Y, oColour} == '0, "reset_xyc", {12'd0, oStart_X, oStart_Y, oColour}, 0);
    reset = 1'b0;
    @(negedge clk);
    // Stray done pulse while idle must be ignored
    iDrawDone = 1'b1; @(negedge clk); iDrawDone = 1'b0;
    chk(!oBusy, "idle_ignore_done", 32'(oBusy), 0);

    do_update(9'h001, 0); wait_idle(200);
    do_update(9'h011, 0); wait_idle(200);
    do_update(9'h011, !FULL); wait_idle(200);

    // Latest mid-sequence update wins
    do_update(9'h0F0, 0);
    @(negedge clk);
    pulse(9'h100);
    pulse(9'h180);
    expect_frame(9'h180, 0);
    wait_idle(400);

    if (!FULL) begin
      // Update landing exactly in FINISH overrides an older pending mask
      do_update(9'h180, 1);
      @(negedge clk);
      pulse(9'h055);
      repeat (7) @(negedge clk);
      chk(oFrameDone, "finish_alignment", 32'(oFrameDone), 1);
      expect_frame(9'h0AA, 0);
      pulse(9'h0AA);
      wait_idle(400);
    end

    // Reset while waiting for the drawer
    do_update(9'h1FF, 0);
    t = 0;
    while (!outstanding && t < 100) begin @(negedge clk); t++; end
    chk(t < 100, "reach_wait", t, 100);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    m_valid = 0; m_shown = '0;
    @(negedge clk);
    chk(!oBusy && !oPlotBox, "reset_abort", {oBusy, oPlotBox}, 0);
    @(negedge clk);
    reset = 1'b0;
    outstanding = 0;
    repeat (5) @(negedge clk);
    chk(!oBusy, "post_reset_idle", 32'(oBusy), 0);
    do_update(9'h000, 0); wait_idle(300);

    // Randomized updates, some overwritten while busy
    for (int i = 0; i < 25; i++) begin
      drawer_dly = $urandom_range(1, 5);
      m = 9'($urandom_range(0, 511));
      do_update(m, 0);
      if ($urandom_range(0, 2) == 0) begin
        @(negedge clk);
        m = 9'($urandom_range(0, 511));
        pulse(m);
        expect_frame(m, 0);
      end
      wait_idle(600);
    end

    repeat (5) @(negedge clk);
    chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
